// File: rtl/lfsr_countdown_pkg.sv
// Shared LFSR helpers for lfsr_countdown: maximal-length tap masks (widths 3..32),
// single-step function, elaboration-time terminal state and width derivation.
package lfsr_countdown_pkg;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 32;

    // Smallest width (at least 3) whose period 2^w-1 strictly exceeds count.
    function automatic int lfsr_width(longint unsigned count);
        int w;
        w = MIN_WIDTH;
        while ((64'd1 << w) < count + 64'd2) w++;
        return w;
    endfunction

    function automatic logic [31:0] tap_mask(int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_mask(int width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [31:0] lfsr_next(logic [31:0] state, int width);
        return {state[30:0], ^(state & tap_mask(width))} & lfsr_mask(width);
    endfunction

    // Seed (all ones) stepped count times.
    function automatic logic [31:0] lfsr_term(longint unsigned count, int width);
        logic [31:0] s;
        s = lfsr_mask(width);
        for (longint unsigned i = 0; i < count; i++) s = lfsr_next(s, width);
        return s;
    endfunction

endpackage

// File: rtl/lfsr_countdown_core.sv
// lfsr_core: Fibonacci shift-left LFSR register with load-seed / advance / hold
// controls and a combinational next-state output.
module lfsr_core
    import lfsr_countdown_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    localparam logic [WIDTH-1:0] SEED = '1;
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

    assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

    // NOTE: non-blocking so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clock) begin
        if (i_reset || load) begin
            state <= SEED;
        end else if (advance) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_countdown.sv
// LFSR-based countdown timer (one-shot done level or periodic tick).
// Optional XOR-lockup guard enabled by defining LFSR_COUNTDOWN_LOCKUP_GUARD_EN.
module lfsr_countdown
    import lfsr_countdown_pkg::*;
#(
    parameter int unsigned COUNT = 16
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_restart,
    input  logic i_periodic,
    output logic o_done,
    output logic o_tick,
    output logic o_fault
);

    localparam int WIDTH = lfsr_width(64'(COUNT));
    localparam logic [WIDTH-1:0] TERM = WIDTH'(lfsr_term(64'(COUNT), WIDTH));

    if (COUNT < 1 || COUNT > 32'hFFFF_FFFE) begin : g_bad_count
        $error("lfsr_countdown: COUNT must lie in 1 .. 2^32-2");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] next_state;
    logic             load;
    logic             advance;
    logic             tick_next;
    logic             at_term;
    logic             hit;

    lfsr_core #(.WIDTH(WIDTH)) u_core (
        .clock      (clock),
        .i_reset    (i_reset),
        .load       (load),
        .advance    (advance),
        .state      (state),
        .next_state (next_state)
    );

    assign at_term = (state == TERM);
    assign hit     = (next_state == TERM);
    assign o_done  = at_term;

`ifdef LFSR_COUNTDOWN_LOCKUP_GUARD_EN
    logic lockup;
    assign lockup = (state == '0);

    always_ff @(posedge clock) begin
        if (i_reset || i_restart) begin
            o_fault <= 1'b0;
        end else if (lockup) begin
            o_fault <= 1'b1;
        end
    end
`else
    assign o_fault = 1'b0;
`endif

    // Periodic mode reloads the seed instead of entering TERM, so there is no dead cycle.
    always_comb begin
        load      = 1'b0;
        advance   = 1'b0;
        tick_next = 1'b0;
        if (i_restart) begin
            load = 1'b1;
`ifdef LFSR_COUNTDOWN_LOCKUP_GUARD_EN
        end else if (lockup) begin
            load = 1'b1;
`endif
        end else if (at_term) begin
            load = i_enable && i_periodic;
        end else if (i_enable) begin
            tick_next = hit;
            load      = hit && i_periodic;
            advance   = !(hit && i_periodic);
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_tick <= 1'b0;
        end else begin
            o_tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_lfsr_countdown.sv
// Self-checking bench for lfsr_countdown: four instances (COUNT 16, 5, 1, 14) checked
// every cycle against a binary-position model, plus literal latency/tick-count pins.
`timescale 1ns/1ps
module tb_lfsr_countdown;

    localparam int NDUT = 4;
    localparam int C [NDUT] = '{16, 5, 1, 14};

    logic            clock = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_enable = 1'b0;
    logic            i_restart = 1'b0;
    logic            i_periodic = 1'b0;
    logic [NDUT-1:0] done;
    logic [NDUT-1:0] tick;
    logic [NDUT-1:0] fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    lfsr_countdown #(.COUNT(16)) dut16 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_restart(i_restart),
        .i_periodic(i_periodic), .o_done(done[0]), .o_tick(tick[0]), .o_fault(fault[0]));
    lfsr_countdown #(.COUNT(5)) dut5 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_restart(i_restart),
        .i_periodic(i_periodic), .o_done(done[1]), .o_tick(tick[1]), .o_fault(fault[1]));
    lfsr_countdown #(.COUNT(1)) dut1 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_restart(i_restart),
        .i_periodic(i_periodic), .o_done(done[2]), .o_tick(tick[2]), .o_fault(fault[2]));
    lfsr_countdown #(.COUNT(14)) dut14 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_restart(i_restart),
        .i_periodic(i_periodic), .o_done(done[3]), .o_tick(tick[3]), .o_fault(fault[3]));

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: count enabled cycles since seed as a plain integer.
    int pos [NDUT];
    bit at_term [NDUT];
    bit tick_m [NDUT];
    int en_cnt = 0;
    int cyc = 0;
    bit checking = 1'b0;

    always @(posedge clock) begin
        if (i_reset || i_restart) begin
            en_cnt = 0;
            cyc    = 0;
        end else begin
            cyc++;
            if (i_enable) en_cnt++;
        end
        for (int i = 0; i < NDUT; i++) begin
            tick_m[i] = 1'b0;
            if (i_reset || i_restart) begin
                pos[i]     = 0;
                at_term[i] = 1'b0;
            end else if (at_term[i]) begin
                if (i_enable && i_periodic) at_term[i] = 1'b0;
            end else if (i_enable) begin
                if (pos[i] + 1 == C[i]) begin
                    tick_m[i]  = 1'b1;
                    pos[i]     = 0;
                    at_term[i] = !i_periodic;
                end else begin
                    pos[i]++;
                end
            end
        end
    end

    // Logs for the literal pins.
    int tick_hits [NDUT];
    int done_at [NDUT];
    int done_cyc [NDUT];
    int tick5_at [$];

    task automatic clear_logs();
        @(posedge clock);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            tick_hits[i] = 0;
            done_at[i]   = -1;
            done_cyc[i]  = -1;
        end
        tick5_at.delete();
    endtask

    always @(negedge clock) begin
        if (checking) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("done[C=%0d] t=%0t", C[i], $time), longint'(done[i]), longint'(at_term[i]));
                check($sformatf("tick[C=%0d] t=%0t", C[i], $time), longint'(tick[i]), longint'(tick_m[i]));
                check($sformatf("fault[C=%0d] t=%0t", C[i], $time), longint'(fault[i]), 0);
                if (tick[i]) tick_hits[i]++;
                if (done[i] && done_at[i] < 0) begin
                    done_at[i]  = en_cnt;
                    done_cyc[i] = cyc;
                end
            end
            if (tick[1]) tick5_at.push_back(en_cnt);
        end
    end

    task automatic step(input logic en, input logic per, input logic rs, input logic rst);
        @(negedge clock);
        i_enable   = en;
        i_periodic = per;
        i_restart  = rs;
        i_reset    = rst;
    endtask

    localparam int NMIX = 20;
    localparam logic [1:0] MIX [NMIX] = '{  // {enable, periodic}
        2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11,
        2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10};

    initial begin
        int n;

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        clear_logs();
        checking = 1'b1;
        check("reset_done", longint'(done), 0);
        check("reset_tick", longint'(tick), 0);
        check("reset_fault", longint'(fault), 0);

        // One-shot, enable held high: done after COUNT enables, then stable
        clear_logs();
        repeat (40) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("oneshot_done_at_16", done_at[0], 16);
        check("oneshot_done_at_5", done_at[1], 5);
        check("oneshot_done_at_1", done_at[2], 1);
        check("oneshot_done_at_14", done_at[3], 14);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("oneshot_ticks_C%0d", C[i]), tick_hits[i], 1);
        check("oneshot_done_held", longint'(done), 15);

        // Enable toggling 0/1: 16 enables take 32 cycles
        step(0, 0, 0, 1);
        clear_logs();
        for (int k = 1; k <= 40; k++) step(k % 2 == 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("toggle_done_cycle_16", done_cyc[0], 32);
        check("toggle_done_en_16", done_at[0], 16);

        // Periodic, 23 enables
        step(0, 1, 0, 1);
        clear_logs();
        repeat (23) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("periodic_ticks_C16", tick_hits[0], 1);
        check("periodic_ticks_C5", tick_hits[1], 4);
        check("periodic_ticks_C1", tick_hits[2], 23);
        check("periodic_ticks_C14", tick_hits[3], 1);
        check("periodic_tick5_count", tick5_at.size(), 4);
        for (int k = 0; k < tick5_at.size(); k++)
            check($sformatf("periodic_tick5_pos%0d", k), tick5_at[k], 5 * (k + 1));
        for (int i = 0; i < NDUT; i++)
            check($sformatf("periodic_no_done_C%0d", C[i]), done_at[i], -1);

        // Restart at enabled count 7 needs a full COUNT again
        step(0, 0, 0, 1);
        clear_logs();
        repeat (7) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        clear_logs();
        repeat (20) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("restart_done_at_16", done_at[0], 16);
        check("restart_done_at_14", done_at[3], 14);
        check("restart_done_at_5", done_at[1], 5);

        // Reset and restart together, with periodic enable pending
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);
        check("rst_rs_tick", longint'(tick), 0);
        check("rst_rs_fault", longint'(fault), 0);
        check("rst_rs_done", longint'(done), 0);

        // Mode changes at TERM and mid-count (model-checked every cycle)
        repeat (5) step(1, 0, 0, 0);
        for (int k = 0; k < NMIX; k++) step(MIX[k][1], MIX[k][0], 0, 0);
        repeat (16) step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Lockup: drive the COUNT=16 register to zero
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        checking = 1'b0;
        force dut16.u_core.state = '0;
        #1;
        release dut16.u_core.state;
`ifdef LFSR_COUNTDOWN_LOCKUP_GUARD_EN
        step(1, 0, 0, 0);
        @(posedge clock);
        #1;
        check("guard_state_seed", longint'(dut16.u_core.state), 31);
        check("guard_fault_set", longint'(fault[0]), 1);
        check("guard_no_tick", longint'(tick[0]), 0);
        n = 0;
        do begin
            step(1, 0, 0, 0);
            @(posedge clock);
            #1;
            n++;
        end while (!done[0] && n < 40);
        check("guard_recount", n, 16);
        check("guard_fault_sticky", longint'(fault[0]), 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("guard_fault_cleared", longint'(fault[0]), 0);
`else
        n = 0;
        repeat (6) begin
            step(1, 0, 0, 0);
            @(posedge clock);
            #1;
            if (dut16.u_core.state == '0) n++;
        end
        check("noguard_state_stuck", n, 6);
        check("noguard_fault", longint'(fault[0]), 0);
        check("noguard_done", longint'(done[0]), 0);
        check("noguard_tick", longint'(tick[0]), 0);
`endif

        step(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
